// File: rtl/wash_pkg.sv
// Shared types and constants for the wash plant sensor model and its controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wash_pkg;

  // Detergent dosing sequence inside the plant model.
  typedef enum logic [1:0] {
    DET_IDLE   = 2'd0,
    DET_DOSING = 2'd1,
    DET_DONE   = 2'd2
  } det_state_t;

  // Controller state encodings, kept here so plant and controller agree.
  typedef enum logic [3:0] {
    CTRL_IDLE        = 4'd0,
    CTRL_FILL_SOAP   = 4'd1,
    CTRL_ADD_SOAP    = 4'd2,
    CTRL_WASH        = 4'd3,
    CTRL_DRAIN_SOAP  = 4'd4,
    CTRL_FILL_RINSE  = 4'd5,
    CTRL_RINSE       = 4'd6,
    CTRL_DRAIN_RINSE = 4'd7,
    CTRL_SPIN        = 4'd8,
    CTRL_DONE        = 4'd9
  } ctrl_state_t;

  // Number of consecutive overfill ticks that trip the overflow alarm.
  localparam int OVF_TICKS = 4;

  // Bits needed to hold a count in the range 0..n (never less than 1).
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/wash_tick_gen.sv
// Prescaler: emits a one-clk tick strobe every PRESCALE clks (every clk when PRESCALE=1).
// Latency: tick is combinational from the registered divider count.
// Backpressure: none; free-running after reset.
module wash_tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  // Divider count wraps at PRESCALE-1; stays at 0 when PRESCALE=1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/wash_plant_sensor_model.sv
// Plant model: turns controller actuator commands into level, dose and timer sensor flags.
// Latency: state advances on plant ticks; every output is registered one clk after its state.
// Backpressure: none; optional overflow_alarm output under `WASH_OVERFLOW_ALARM_EN.
module wash_plant_sensor_model
  import wash_pkg::*;
#(
  parameter int PRESCALE    = 1,
  parameter int LEVEL_MAX   = 8,
  parameter int CYCLE_TICKS = 20,
  parameter int SPIN_TICKS  = 10,
  parameter int DET_TICKS   = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic door_lock,
  input  logic fill_valve_on,
  input  logic drain_valve_on,
  input  logic motor_on,
  input  logic soap_wash,
  input  logic water_wash,
  output logic filled,
  output logic drained,
  output logic detergent_added,
  output logic cycle_timeout,
  output logic spin_timeout
`ifdef WASH_OVERFLOW_ALARM_EN
  ,
  output logic overflow_alarm
`endif
);

  localparam int LW  = cnt_width(LEVEL_MAX);
  localparam int CYW = cnt_width(CYCLE_TICKS);
  localparam int SPW = cnt_width(SPIN_TICKS);
  localparam int DW  = cnt_width(DET_TICKS);

  localparam logic [LW-1:0]  LVL_MAX  = LW'(LEVEL_MAX);
  localparam logic [CYW-1:0] CYC_MAX  = CYW'(CYCLE_TICKS);
  localparam logic [SPW-1:0] SPIN_MAX = SPW'(SPIN_TICKS);
  localparam logic [DW-1:0]  DET_LAST = DW'(DET_TICKS - 1);

  logic           tick;
  logic [LW-1:0]  level;
  logic [CYW-1:0] cyc_cnt;
  logic [SPW-1:0] spin_cnt;
  logic [DW-1:0]  det_cnt, det_cnt_nxt;
  det_state_t     det_state, det_nxt;

  logic fill_only, drain_only, spin_cond, dose_start;

  assign fill_only  = fill_valve_on && !drain_valve_on;
  assign drain_only = drain_valve_on && !fill_valve_on;
  assign spin_cond  = door_lock && drain_valve_on && (level == '0) && soap_wash && water_wash;
  assign dose_start = door_lock && soap_wash && !water_wash &&
                      !fill_valve_on && !drain_valve_on && !motor_on;

  wash_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Water level: integrates fill/drain per tick, saturating at both ends; door lock has no effect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= '0;
    end else if (tick) begin
      if (fill_only && level != LVL_MAX)  level <= level + LW'(1);
      else if (drain_only && level != '0) level <= level - LW'(1);
    end
  end

  // Agitation timer: counts motor ticks, cleared at once when the motor stops or the door unlocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         cyc_cnt <= '0;
    else if (!door_lock || !motor_on)   cyc_cnt <= '0;
    else if (tick && cyc_cnt != CYC_MAX) cyc_cnt <= cyc_cnt + CYW'(1);
  end

  // Spin timer: counts ticks of draining an empty drum in the spin phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            spin_cnt <= '0;
    else if (!spin_cond)                   spin_cnt <= '0;
    else if (tick && spin_cnt != SPIN_MAX) spin_cnt <= spin_cnt + SPW'(1);
  end

  // Detergent FSM state and dose tick counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      det_state <= DET_IDLE;
      det_cnt   <= '0;
    end else begin
      det_state <= det_nxt;
      det_cnt   <= det_cnt_nxt;
    end
  end

  // Detergent FSM next state: the starting tick counts as the first dose tick, one dose per lock.
  always_comb begin
    det_nxt     = det_state;
    det_cnt_nxt = det_cnt;
    case (det_state)
      DET_IDLE: begin
        if (dose_start && tick) begin
          det_cnt_nxt = DW'(1);
          det_nxt     = (DET_TICKS <= 1) ? DET_DONE : DET_DOSING;
        end
      end
      DET_DOSING: begin
        if (!door_lock) begin
          det_nxt     = DET_IDLE;
          det_cnt_nxt = '0;
        end else if (tick) begin
          if (det_cnt == DET_LAST) det_nxt = DET_DONE;
          else                     det_cnt_nxt = det_cnt + DW'(1);
        end
      end
      DET_DONE: begin
        if (!door_lock) begin
          det_nxt     = DET_IDLE;
          det_cnt_nxt = '0;
        end
      end
      default: begin
        det_nxt     = DET_IDLE;
        det_cnt_nxt = '0;
      end
    endcase
  end

  // Registered sensor outputs, one clk behind the internal state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filled          <= 1'b0;
      drained         <= 1'b1;
      detergent_added <= 1'b0;
      cycle_timeout   <= 1'b0;
      spin_timeout    <= 1'b0;
    end else begin
      filled          <= (level == LVL_MAX);
      drained         <= (level == '0);
      detergent_added <= (det_state == DET_DONE);
      cycle_timeout   <= (cyc_cnt == CYC_MAX);
      spin_timeout    <= (spin_cnt == SPIN_MAX);
    end
  end

`ifdef WASH_OVERFLOW_ALARM_EN
  logic [1:0] ovf_cnt;

  // Overflow alarm: sticky once the valve stays open on a full drum for OVF_TICKS ticks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_cnt        <= '0;
      overflow_alarm <= 1'b0;
    end else if (tick) begin
      if (fill_valve_on && level == LVL_MAX) begin
        if (ovf_cnt == 2'(OVF_TICKS - 1)) overflow_alarm <= 1'b1;
        else                              ovf_cnt <= ovf_cnt + 2'd1;
      end else begin
        ovf_cnt <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wash_plant_sensor_model.sv
// Directed bench: expectations are queued as stimulus is driven and checked when outputs are due.
// Two instances: PRESCALE=1 for the main checks, PRESCALE=4 for tick-scaled cycle timing.
// Optional overflow alarm checks compile in with WASH_OVERFLOW_ALARM_EN.
module tb_wash_plant_sensor_model;

  logic clk = 1'b0;
  logic reset;
  logic door_lock, fill_valve_on, drain_valve_on, motor_on, soap_wash, water_wash;
  logic filled, drained, detergent_added, cycle_timeout, spin_timeout;
  logic p4_filled, p4_drained, p4_det, p4_cyc, p4_spin;
  logic ovf0, ovf1;

  always #5 clk = ~clk;

  wash_plant_sensor_model #(.PRESCALE(1)) u0 (
    .clk             (clk),
    .reset           (reset),
    .door_lock       (door_lock),
    .fill_valve_on   (fill_valve_on),
    .drain_valve_on  (drain_valve_on),
    .motor_on        (motor_on),
    .soap_wash       (soap_wash),
    .water_wash      (water_wash),
    .filled          (filled),
    .drained         (drained),
    .detergent_added (detergent_added),
    .cycle_timeout   (cycle_timeout),
    .spin_timeout    (spin_timeout)
`ifdef WASH_OVERFLOW_ALARM_EN
    ,
    .overflow_alarm  (ovf0)
`endif
  );

  wash_plant_sensor_model #(.PRESCALE(4)) u1 (
    .clk             (clk),
    .reset           (reset),
    .door_lock       (door_lock),
    .fill_valve_on   (fill_valve_on),
    .drain_valve_on  (drain_valve_on),
    .motor_on        (motor_on),
    .soap_wash       (soap_wash),
    .water_wash      (water_wash),
    .filled          (p4_filled),
    .drained         (p4_drained),
    .detergent_added (p4_det),
    .cycle_timeout   (p4_cyc),
    .spin_timeout    (p4_spin)
`ifdef WASH_OVERFLOW_ALARM_EN
    ,
    .overflow_alarm  (ovf1)
`endif
  );

`ifndef WASH_OVERFLOW_ALARM_EN
  assign ovf0 = 1'b0;
  assign ovf1 = 1'b0;
`endif

  // sel 0: {filled,drained,detergent_added,cycle_timeout,spin_timeout} of u0
  // sel 1: cycle_timeout of the PRESCALE=4 instance; sel 2: overflow_alarm of u0
  typedef struct {
    string      tag;
    logic [4:0] exp;
    int         sel;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic push(input string tag, input logic [4:0] e, input int sel);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    x.sel = sel;
    sb.push_back(x);
  endtask

  task automatic score();
    exp_t x;
    logic [4:0] obs;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      case (x.sel)
        1:       obs = {4'b0, p4_cyc};
        2:       obs = {4'b0, ovf0};
        default: obs = {filled, drained, detergent_added, cycle_timeout, spin_timeout};
      endcase
      vectors++;
      assert (obs === x.exp) else begin
        miscompares++;
        $error("FAIL %s: observed %b expected %b", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    door_lock = 0; fill_valve_on = 0; drain_valve_on = 0;
    motor_on = 0; soap_wash = 0; water_wash = 0;

    // Reset state and idle after release
    push("reset_state", 5'b01000, 0); step(2); score();
    reset = 1'b1;
    push("idle_after_reset", 5'b01000, 0); step(3); score();

    // Reset in the middle of a fill at level 5, asynchronously
    door_lock = 1; fill_valve_on = 1;
    push("fill_to_5", 5'b00000, 0); step(5); score();
    #2 reset = 1'b0;
    #1 push("async_reset_midfill", 5'b01000, 0); score();
    door_lock = 0; fill_valve_on = 0;
    #1 reset = 1'b1;
    push("no_residual_after_reset", 5'b01000, 0); step(2); score();

    // Fill to full and hold the valve open past full
    door_lock = 1; fill_valve_on = 1;
    push("fill_8clk_not_yet", 5'b00000, 0); step(8); score();
    push("filled_on_clk9", 5'b10000, 0); step(1); score();
    push("fill_saturates", 5'b10000, 0); step(5); score();
`ifdef WASH_OVERFLOW_ALARM_EN
    push("overflow_set", 5'b00001, 2); score();
    fill_valve_on = 0;
    push("overflow_sticky", 5'b00001, 2); step(3); score();
`endif

    // Detergent dose: 3 ticks plus the output register
    fill_valve_on = 0; soap_wash = 1; water_wash = 0;
    push("dose_pending", 5'b10000, 0); step(3); score();
    push("dose_done", 5'b10100, 0); step(1); score();
    soap_wash = 0;
    push("dose_held_soap_off", 5'b10100, 0); step(2); score();
    soap_wash = 1;
    push("dose_held_reenter", 5'b10100, 0); step(5); score();
    door_lock = 0;
    push("dose_cleared_unlock", 5'b10000, 0); step(2); score();
    door_lock = 1;
    push("dose_new_lock", 5'b10100, 0); step(4); score();
    soap_wash = 0; door_lock = 0; step(2);

    // Drain from full then spin
    door_lock = 1; drain_valve_on = 1; soap_wash = 1; water_wash = 1;
    push("draining", 5'b00000, 0); step(8); score();
    push("drained_after_8", 5'b01000, 0); step(1); score();
    push("spin_counting", 5'b01000, 0); step(9); score();
    push("spin_timeout", 5'b01001, 0); step(1); score();
    door_lock = 0;
    push("spin_cleared_unlock", 5'b01000, 0); step(2); score();
    door_lock = 1; step(5);
    door_lock = 0; step(1);
    door_lock = 1;
    push("spin_restart_from_0", 5'b01000, 0); step(10); score();
    push("spin_timeout_again", 5'b01001, 0); step(1); score();
    door_lock = 0; drain_valve_on = 0; soap_wash = 0; water_wash = 0; step(2);

    // Agitation timer; reset first so the PRESCALE=4 tick phase is known
    reset = 1'b0; step(1);
    reset = 1'b1; door_lock = 1; motor_on = 1;
    push("cycle_counting", 5'b01000, 0); push("p4_cycle_counting", 5'b00000, 1);
    step(20); score();
    push("cycle_timeout", 5'b01010, 0); step(1); score();
    push("p4_cycle_at_80", 5'b00000, 1); push("cycle_timeout_held", 5'b01010, 0);
    step(59); score();
    push("p4_cycle_timeout", 5'b00001, 1); step(1); score();
    motor_on = 0;
    push("cycle_cleared", 5'b01000, 0); push("p4_cycle_cleared", 5'b00000, 1);
    step(2); score();

    // Fill and drain together hold the level at 4
    fill_valve_on = 1; step(4);
    drain_valve_on = 1;
    push("fill_drain_hold", 5'b00000, 0); step(6); score();
    fill_valve_on = 0;
    push("drain_from_4", 5'b00000, 0); step(4); score();
    push("drained_after_4", 5'b01000, 0); step(1); score();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wash_plant_sensor_model.md
Name: wash_plant_sensor_model

Overview:
Plant-side counterpart of the washing machine controller. Consumes the controller's actuator commands (valves, motor, door lock, phase flags) and generates the sensor and timer inputs the controller expects: filled, drained, detergent_added, cycle_timeout and spin_timeout. Used as the closed-loop drum/sensor model in system benches and as the timer/level-sensing front end on FPGA demos.

Parameters:
PRESCALE, 1, clk cycles per plant tick (all counters advance only on tick); must be >=1.
LEVEL_MAX, 8, water level at which filled asserts.
CYCLE_TICKS, 20, motor ticks before cycle_timeout asserts.
SPIN_TICKS, 10, spin ticks before spin_timeout asserts.
DET_TICKS, 3, dosing ticks before detergent_added asserts.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
door_lock  in  1  controller door lock command
fill_valve_on  in  1  fill valve command
drain_valve_on  in  1  drain valve command
motor_on  in  1  drum motor command
soap_wash  in  1  controller soap-phase flag
water_wash  in  1  controller rinse-phase flag
filled  out  1  level == LEVEL_MAX
drained  out  1  level == 0
detergent_added  out  1  dose complete
cycle_timeout  out  1  wash/rinse agitation time elapsed
spin_timeout  out  1  spin time elapsed

Behaviour:
- Reset (reset=0, async): level=0, all timers=0, detergent FSM=DET_IDLE, prescaler=0; outputs filled=0, drained=1, detergent_added=0, cycle_timeout=0, spin_timeout=0.
- All outputs registered; each reflects internal state one clk after the state update.
- Tick: one-clk strobe every PRESCALE clks; PRESCALE=1 gives a tick every clk.
- Level (width $clog2(LEVEL_MAX+1)): on tick, fill-only -> +1, saturating at LEVEL_MAX; drain-only -> -1, saturating at 0; both or neither -> hold.
- Cycle timer: on tick with motor_on=1 -> +1, saturating at CYCLE_TICKS. cycle_timeout=1 while count==CYCLE_TICKS. motor_on=0 clears the count on the next clk, independent of tick.
- Spin timer: counts on tick while drain_valve_on=1 && level==0 && soap_wash && water_wash; saturates at SPIN_TICKS; spin_timeout=1 at saturation. Cleared on the next clk when the condition drops.
- Detergent FSM, states DET_IDLE, DET_DOSING, DET_DONE:
  - IDLE->DOSING when door_lock && soap_wash && !water_wash && no valve or motor active.
  - DOSING: counts ticks; DET_TICKS reached -> DONE. Abort -> IDLE if door_lock falls.
  - DONE: detergent_added=1; returns to IDLE only when door_lock=0.
  - Result: one dose per locked wash.
- door_lock=0: cycle and spin timers cleared and held at 0. Level is unaffected (water physically remains).
- Mid-operation reset: everything returns to reset values immediately; no residual pulses.

Optional Feature:
WASH_OVERFLOW_ALARM_EN.
- Defined: adds output overflow_alarm (1 bit). It sets when fill_valve_on=1 with level==LEVEL_MAX for 4 consecutive ticks, is sticky, and clears only on reset.
- Undefined: no port, no logic. All other behaviour is identical.

Decomposition:
- Package wash_pkg: detergent FSM state typedef (DET_IDLE/DET_DOSING/DET_DONE), controller state encodings shared with the controller, width helper constants.
- Sub-module wash_tick_gen: prescaler producing the tick strobe, parameter PRESCALE.

Test Plan:
1. Reset asserted then released, idle inputs -> drained=1, all other outputs 0; reset mid-fill at level 5 -> level 0 and drained=1 within 1 clk, asynchronously.
2. door_lock=1, fill_valve_on=1 for 8 clks (PRESCALE=1) -> filled rises on clk 9; holding fill 5 more clks keeps level at 8 (no overflow/wrap).
3. soap_wash=1, water_wash=0, idle actuators -> detergent_added=1 after 3 ticks +1 clk; re-entering the condition without unlocking -> no second dose.
4. motor_on=1 for 20 ticks -> cycle_timeout=1; drop motor_on -> cycle_timeout=0 next clk; with PRESCALE=4 -> asserts after 80 clks.
5. Level 8, drain_valve_on=1, soap_wash=water_wash=1 -> drained after 8 ticks, then spin_timeout after 10 more ticks; drop door_lock mid-spin -> timer cleared.
6. With WASH_OVERFLOW_ALARM_EN defined: full level plus fill_valve_on for 4 ticks -> overflow_alarm=1 and it stays set after the valve closes; fill and drain together at level 4 -> level holds at 4.
